// File: rtl/fp_multiply_seq_if.sv
// Request/response bundle for the sequential single-precision multiplier.
// The requester drives operands and start; the multiplier returns result, busy and done.
interface fp_multiply_seq_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start, multiplicand, multiplier,
    input  result, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output result, busy, done
  );
endinterface

// File: rtl/fp_multiply_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product,
// truncating normalisation, subnormal flush-to-zero and early exit for special operands.
module fp_multiply_seq (
  input  logic               clk,
  input  logic               rst,
  fp_multiply_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [47:0]        mcand_r;
  logic [23:0]        mplier_r;
  logic [47:0]        acc_r;
  logic [4:0]         count_r;
  logic [31:0]        result_r, result_nxt_s;
  logic               busy_r;
  logic               done_r;

  logic               special_s;
  logic signed [9:0]  norm_exp_s;
  logic [22:0]        norm_mant_s;

  function automatic logic is_special(input logic [31:0] op);
    return (op[30:23] == 8'd0) || (op[30:23] == 8'hFF);
  endfunction

  // NaN dominates, then inf x zero, then inf, then zero.
  function automatic logic [31:0] special_result(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    s      = a[31] ^ b[31];
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      return 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      return {s, 8'hFF, 23'd0};
    end else begin
      return {s, 31'd0};
    end
  endfunction

  function automatic logic [31:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [22:0] m);
    if (e >= 10'sd255) begin
      return {s, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      return {s, 31'd0};
    end else begin
      return {s, e[7:0], m};
    end
  endfunction

  assign special_s   = is_special(bus.multiplicand) || is_special(bus.multiplier);
  assign norm_exp_s  = acc_r[47] ? (exp_r + 10'sd1) : exp_r;
  assign norm_mant_s = acc_r[47] ? acc_r[46:24] : acc_r[45:23];

  // Next-state and next-result decode.
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = result_r;
    case (state_r)
      IDLE: begin
        if (bus.start && special_s) begin
          state_nxt_s  = DONE;
          result_nxt_s = special_result(bus.multiplicand, bus.multiplier);
        end else if (bus.start) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (count_r == 5'd23) begin
          state_nxt_s = NORM;
        end else begin
          state_nxt_s = MUL;
        end
      end
      NORM: begin
        state_nxt_s  = DONE;
        result_nxt_s = pack_result(sign_r, norm_exp_s, norm_mant_s);
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      exp_r    <= 10'sd0;
      mcand_r  <= 48'd0;
      mplier_r <= 24'd0;
      acc_r    <= 48'd0;
      count_r  <= 5'd0;
      result_r <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      result_r <= result_nxt_s;
      busy_r   <= (state_nxt_s == MUL) || (state_nxt_s == NORM);
      done_r   <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start && !special_s) begin
            sign_r   <= bus.multiplicand[31] ^ bus.multiplier[31];
            exp_r    <= $signed({2'b00, bus.multiplicand[30:23]})
                      + $signed({2'b00, bus.multiplier[30:23]}) - 10'sd127;
            mcand_r  <= {24'd0, 1'b1, bus.multiplicand[22:0]};
            mplier_r <= {1'b1, bus.multiplier[22:0]};
            acc_r    <= 48'd0;
            count_r  <= 5'd0;
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[46:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[23:1]};
          count_r  <= count_r + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_fp_multiply_seq.sv
// Directed bench for fp_multiply_seq: latency, special cases, overflow/underflow,
// ignored starts, operand isolation and mid-operation reset.
module tb_fp_multiply_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fp_multiply_seq_if bus ();

  fp_multiply_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bd();
    return {30'd0, bus.busy, bus.done};
  endfunction

  // Returns at the T+1 sample point with start already dropped.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    tick();
    bus.start = 1'b0;
  endtask

  // From cycle T+k0, checks busy through T+25, then done and result at T+26 (left there).
  task automatic run_normal(input string tag, input logic [31:0] exp, input int k0);
    for (int k = k0; k <= 25; k++) begin
      check($sformatf("%s_busy_t%0d", tag, k), bd(), 32'd2);
      tick();
    end
    check($sformatf("%s_done_t26", tag), bd(), 32'd1);
    check($sformatf("%s_result", tag), bus.result, exp);
  endtask

  task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    accept(a, b);
    check($sformatf("%s_done_t1", tag), bd(), 32'd1);
    check($sformatf("%s_result", tag), bus.result, exp);
    tick();
    check($sformatf("%s_idle_t2", tag), bd(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dones;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    tick(); tick(); tick();
    check("reset_result", bus.result, 32'h0000_0000);
    check("reset_busy_done", bd(), 32'd0);

    // Reset wins over a simultaneous start.
    bus.start        = 1'b1;
    bus.multiplicand = 32'h4000_0000;
    bus.multiplier   = 32'h4040_0000;
    tick();
    check("rst_priority", bd(), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    check("rst_priority_idle", bd(), 32'd0);

    accept(32'h4000_0000, 32'h4040_0000);
    run_normal("mul_2x3", 32'h40C0_0000, 1);
    tick();
    check("mul_2x3_pulse_end", bd(), 32'd0);

    // Start held through DONE: ignored on the DONE edge, accepted one cycle later.
    accept(32'h3FC0_0000, 32'h3FC0_0000);
    run_normal("mul_1p5x1p5", 32'h4010_0000, 1);
    bus.start        = 1'b1;
    bus.multiplicand = 32'hC000_0000;
    bus.multiplier   = 32'h3F00_0000;
    tick();
    check("start_on_done_ignored", bd(), 32'd0);
    check("result_held_idle", bus.result, 32'h4010_0000);
    tick();
    bus.start = 1'b0;
    run_normal("mul_m2x0p5", 32'hBF80_0000, 1);
    tick();

    special("zero_x_5", 32'h8000_0000, 32'h40A0_0000, 32'h8000_0000);
    special("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    special("nan_x_1", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    special("minf_x_2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);

    accept(32'h7F00_0000, 32'h7F00_0000);
    run_normal("overflow", 32'h7F80_0000, 1);
    tick();
    accept(32'h0080_0000, 32'h0080_0000);
    run_normal("underflow", 32'h0000_0000, 1);
    tick();

    // Second start at T+5 and operand churn during MUL must not disturb the result.
    accept(32'h4000_0000, 32'h4040_0000);
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) begin
        bus.start        = 1'b1;
        bus.multiplicand = 32'h3FC0_0000;
        bus.multiplier   = 32'h3FC0_0000;
      end else if (k > 5) begin
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      check($sformatf("isolate_busy_t%0d", k), bd(), 32'd2);
      tick();
    end
    check("isolate_done_t26", bd(), 32'd1);
    check("isolate_result", bus.result, 32'h40C0_0000);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done) dones++;
    end
    check("isolate_single_done", dones, 32'd0);

    // Reset at T+10 aborts with no done and clears the result.
    accept(32'h3FC0_0000, 32'h3FC0_0000);
    for (int k = 1; k <= 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_done", bd(), 32'd0);
    check("abort_result", bus.result, 32'h0000_0000);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("abort_no_activity", dones, 32'd0);
    accept(32'hC000_0000, 32'h3F00_0000);
    run_normal("after_abort", 32'hBF80_0000, 1);
    tick();
    check("after_abort_pulse_end", bd(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_multiply_seq.md
FP_MULTIPLY_SEQ -- requirements
Module: fp_multiply_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 multiplicand  input  32  IEEE-754 single operand A; sampled on an accepted start.
REQ-006 multiplier  input  32  IEEE-754 single operand B; sampled on an accepted start.
REQ-007 result  output  32  registered product; held from done until the next accepted start.
REQ-008 busy  output  1  high in MUL and NORM.
REQ-009 done  output  1  one-cycle pulse, high only in DONE.

Function
REQ-010 FSM states SHALL be IDLE, MUL, NORM and DONE, and DONE SHALL always go to IDLE on the next cycle.
REQ-011 Start is accepted only in IDLE; start in any other state SHALL be ignored, with no effect on operands or state.
REQ-012 On accept, both operands SHALL be latched and sign = A[31] ^ B[31].
REQ-013 Operand classes: zero when exp == 0 (subnormals are flushed to zero); inf when exp == 255 and frac == 0; NaN when exp == 255 and frac != 0.
REQ-014 Special cases SHALL go IDLE -> DONE directly, so done is high at T+1, where T is the accept edge.
REQ-015 Any NaN operand, or inf x zero, SHALL give 0x7FC00000.
REQ-016 Inf x nonzero SHALL give {sign, 8'hFF, 23'b0}.
REQ-017 Zero x finite SHALL give {sign, 31'b0}.
REQ-018 The normal path SHALL load 24-bit mantissas {1, frac} and a 48-bit accumulator, then enter MUL with a 5-bit count of 0.
REQ-019 MUL SHALL run one shift-add iteration per cycle (add the shifted multiplicand when the current multiplier bit is 1) for exactly 24 cycles, T+1..T+24.
REQ-020 MUL SHALL go to NORM after count == 23; NORM occupies T+25 and done is high at T+26.
REQ-021 The exponent SHALL be computed as signed 10-bit ea + eb - 127.
REQ-022 NORM: if product[47] == 1, mantissa = product[46:24] and the exponent increments by 1; otherwise mantissa = product[45:23].
REQ-023 Rounding SHALL be truncation (round toward zero).
REQ-024 A final exponent >= 255 SHALL give {sign, 8'hFF, 23'b0}.
REQ-025 A final exponent <= 0 SHALL give {sign, 31'b0}.
REQ-026 result SHALL update only on the cycle entering DONE.
REQ-027 Changes on multiplicand/multiplier after accept SHALL have no effect on the operation in progress.
REQ-028 Start high on the DONE cycle SHALL be ignored; a new start is accepted from IDLE one cycle later.

Reset
REQ-029 On rst, state = IDLE and result = 0x00000000, busy = 0, done = 0, with the accumulator and count cleared.
REQ-030 rst asserted mid-operation (MUL or NORM) SHALL abort the operation with no done pulse, and result SHALL read 0 afterwards.
REQ-031 rst SHALL take priority over start on the same edge.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- 0x40000000 x 0x40400000 (2.0 x 3.0) -> busy T+1..T+25, done at T+26, result 0x40C00000.
- 0x3FC00000 x 0x3FC00000 (1.5 x 1.5) -> normalise shift taken, result 0x40100000; 0xC0000000 x 0x3F000000 -> 0xBF800000.
- 0x80000000 x 0x40A00000 -> done at T+1, result 0x80000000; 0x7F800000 x 0x00000000 -> done at T+1, result 0x7FC00000.
- 0x7F000000 x 0x7F000000 -> overflow, result 0x7F800000; 0x00800000 x 0x00800000 -> underflow, result 0x00000000.
- Start at T, second start with new operands at T+5, operand inputs toggled during MUL -> single done at T+26, result from the first operands only.
- rst asserted at T+10 of a normal operation -> busy 0 and result 0 from the next cycle, no done; a new start afterwards completes normally with 26-cycle latency.
